// File: rtl/cla_multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
//   state_t    : sequencer FSM encoding (IDLE, RUN, DONE)
//   total_bits : full operand width derived from slice width and slice count
package cla_multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int total_bits(input int width, input int words);
        return width * words;
    endfunction

endpackage

// File: rtl/cla_multiword_add_seq_cla.sv
// Single WIDTH-bit carry-lookahead adder slice.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of bit WIDTH-1
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products form:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    // so no carry depends on a previously computed carry.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin : g_carry
            logic cc;
            logic term;
            term = cin;
            for (int k = 0; k <= i; k++) term = term & p[k];
            cc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                cc = cc | term;
            end
            c[i+1] = cc;
        end
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/cla_multiword_add_seq.sv
// Multi-precision add/subtract sequencer. One WIDTH-bit CLA slice is reused
// over WORDS cycles (LSB slice first) with the carry registered between slices.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : command handshake (accepted only in IDLE)
//   a, b, carry_in, sub  : operands and mode (sub=1 computes a-b)
//   out_valid / out_ready: result handshake
//   sum, carry_out       : TOTAL-bit result and carry out of the top bit
//   overflow             : two's-complement overflow of the full operation
module cla_multiword_add_seq
    import cla_multiword_add_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   carry_in,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int TOTAL = total_bits(WIDTH, WORDS);
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t state, state_next;

    logic [TOTAL-1:0] a_reg, b_reg, res_reg;
    logic [TOTAL-1:0] b_eff, slice_ext, res_next;
    logic [IDXW-1:0]  idx;
    logic             carry_reg;
    logic             a_sign, b_sign;
    logic             last;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_co;

    carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
        .a    (a_reg[WIDTH-1:0]),
        .b    (b_reg[WIDTH-1:0]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_co)
    );

    assign b_eff = sub ? ~b : b;
    assign last  = (idx == IDXW'(WORDS - 1));

    // Result enters at the MSB end and shifts right, so after WORDS slices
    // the first (LSB) slice has landed in the bottom word.
    assign slice_ext = TOTAL'(slice_sum);
    assign res_next  = (res_reg >> WIDTH) | (slice_ext << (TOTAL - WIDTH));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b_eff;
                        res_reg   <= '0;
                        idx       <= '0;
                        // Subtract is a + ~b + 1; carry_in is ignored then.
                        carry_reg <= sub ? 1'b1 : carry_in;
                        a_sign    <= a[TOTAL-1];
                        b_sign    <= b_eff[TOTAL-1];
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> WIDTH;
                    b_reg     <= b_reg >> WIDTH;
                    res_reg   <= res_next;
                    carry_reg <= slice_co;
                    idx       <= idx + 1'b1;
                    if (last) begin
                        sum       <= res_next;
                        carry_out <= slice_co;
                        overflow  <= (a_sign == b_sign) && (res_next[TOTAL-1] != a_sign);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
